// File: rtl/wb_tlc_pkg.sv
// Shared TLP request/completion definitions: fmt_type codes,
// header word indices and decoder state encoding.
package wb_tlc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DAT  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam logic [7:0] FT_MRD32 = 8'h00;
    localparam logic [7:0] FT_MRD64 = 8'h20;
    localparam logic [7:0] FT_MWR32 = 8'h40;
    localparam logic [7:0] FT_MWR64 = 8'h60;

    localparam logic [2:0] HW_LEN      = 3'd1;
    localparam logic [2:0] HW_RID      = 3'd2;
    localparam logic [2:0] HW_TAG      = 3'd3;
    localparam logic [2:0] HW_LAST_3DW = 3'd5;
    localparam logic [2:0] HW_LAST_4DW = 3'd7;

    function automatic logic ft_supported(input logic [7:0] ft);
        return (ft == FT_MRD32) || (ft == FT_MRD64) ||
               (ft == FT_MWR32) || (ft == FT_MWR64);
    endfunction

endpackage

// File: rtl/wb_tlc_req_dec.sv
// Inbound memory request decoder: parses 16-bit TLP words into
// request fields and forwards memory-write payload.
module wb_tlc_req_dec
    import wb_tlc_pkg::*;
(
    input  logic        wb_clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_wen,
    output logic        read,
    output logic [23:0] tran_id,
    output logic [9:0]  tran_length,
    output logic [7:0]  tran_be,
    output logic [4:0]  tran_addr,
    output logic [2:0]  tran_tc,
    output logic [1:0]  tran_attr,
    output logic [31:0] addr,
    output logic [15:0] wr_dat,
    output logic        wr_valid,
    output logic        wr_start,
    output logic        wr_done,
    output logic        unsup,
    output logic        err
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [10:0] cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic        is_4dw_q, is_4dw_d;
    logic        over_q, over_d;
    logic [23:0] id_q, id_d;
    logic [9:0]  len_q, len_d;
    logic [7:0]  be_q, be_d;
    logic [2:0]  tc_q, tc_d;
    logic [1:0]  attr_q, attr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wr_dat_q, wr_dat_d;
    logic        wr_valid_q, wr_valid_d;
    logic        wr_start_q, wr_start_d;
    logic        wr_done_q, wr_done_d;
    logic        read_q, read_d;
    logic        unsup_q, unsup_d;
    logic        err_q, err_d;

    logic [2:0]  hdr_last;
    logic [10:0] cnt_last;

    assign hdr_last = is_4dw_q ? HW_LAST_4DW : HW_LAST_3DW;
    // 2*length-1 words; length 0 wraps to 2047 (1024 DW)
    assign cnt_last = {len_q - 10'd1, 1'b1};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        is_4dw_d   = is_4dw_q;
        over_d     = over_q;
        id_d       = id_q;
        len_d      = len_q;
        be_d       = be_q;
        tc_d       = tc_q;
        attr_d     = attr_q;
        addr_d     = addr_q;
        wr_dat_d   = wr_dat_q;
        wr_valid_d = 1'b0;
        wr_start_d = 1'b0;
        wr_done_d  = 1'b0;
        read_d     = 1'b0;
        unsup_d    = 1'b0;
        err_d      = 1'b0;
        if (din_wen) begin
            if (din_sop) begin
                err_d    = (state_q != ST_IDLE);
                over_d   = 1'b0;
                idx_d    = HW_LEN;
                is_wr_d  = din[14];
                is_4dw_d = din[13];
                id_d     = '0;
                len_d    = '0;
                be_d     = '0;
                tc_d     = '0;
                attr_d   = '0;
                addr_d   = '0;
                if (ft_supported(din[15:8])) begin
                    tc_d = din[6:4];
                    if (din_eop) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    unsup_d = 1'b1;
                    state_d = din_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (din_eop && over_q) err_d = 1'b1;
                        if (din_eop) over_d = 1'b0;
                    end
                    ST_HDR: begin
                        idx_d = idx_q + 3'd1;
                        case (idx_q)
                            HW_LEN: begin
                                attr_d = din[13:12];
                                len_d  = din[9:0];
                            end
                            HW_RID: id_d[23:8] = din;
                            HW_TAG: begin
                                id_d[7:0] = din[15:8];
                                be_d      = {din[3:0], din[7:4]};
                            end
                            default: ;
                        endcase
                        if (idx_q == hdr_last - 3'd1) addr_d[31:16] = din;
                        if (idx_q == hdr_last) begin
                            addr_d[15:0] = {din[15:2], 2'b00};
                            cnt_d        = '0;
                            if (!is_wr_q) begin
                                read_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else if (din_eop) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DAT;
                            end
                        end else if (din_eop) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DAT: begin
                        wr_valid_d = 1'b1;
                        wr_dat_d   = din;
                        wr_start_d = (cnt_q == '0);
                        cnt_d      = cnt_q + 11'd1;
                        if (cnt_q == cnt_last) begin
                            wr_done_d = 1'b1;
                            over_d    = !din_eop;
                            state_d   = ST_IDLE;
                        end else if (din_eop) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (din_eop) state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            is_wr_q    <= 1'b0;
            is_4dw_q   <= 1'b0;
            over_q     <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            be_q       <= '0;
            tc_q       <= '0;
            attr_q     <= '0;
            addr_q     <= '0;
            wr_dat_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_start_q <= 1'b0;
            wr_done_q  <= 1'b0;
            read_q     <= 1'b0;
            unsup_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            is_4dw_q   <= is_4dw_d;
            over_q     <= over_d;
            id_q       <= id_d;
            len_q      <= len_d;
            be_q       <= be_d;
            tc_q       <= tc_d;
            attr_q     <= attr_d;
            addr_q     <= addr_d;
            wr_dat_q   <= wr_dat_d;
            wr_valid_q <= wr_valid_d;
            wr_start_q <= wr_start_d;
            wr_done_q  <= wr_done_d;
            read_q     <= read_d;
            unsup_q    <= unsup_d;
            err_q      <= err_d;
        end
    end

    assign read        = read_q;
    assign tran_id     = id_q;
    assign tran_length = len_q;
    assign tran_be     = be_q;
    assign tran_addr   = addr_q[6:2];
    assign tran_tc     = tc_q;
    assign tran_attr   = attr_q;
    assign addr        = addr_q;
    assign wr_dat      = wr_dat_q;
    assign wr_valid    = wr_valid_q;
    assign wr_start    = wr_start_q;
    assign wr_done     = wr_done_q;
    assign unsup       = unsup_q;
    assign err         = err_q;

endmodule
